// File: rtl/weight_packer_16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : weight_packer_16_pkg
// Brief    : Shared widths and state encodings for the weight packer.
// Revision : 1.0
// ============================================================================
package weight_packer_16_pkg;

    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int PACK_LANES       = 16;
    localparam int DEF_CNT_W        = 5;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } pack_state_e;

endpackage : weight_packer_16_pkg
`default_nettype wire

// File: rtl/weight_packer_16.sv
`default_nettype none
// ============================================================================
// Module   : weight_packer_16
// Brief    : Packs up to 16 serial operands into one 16-lane word for the adder.
// Revision : 1.0
// ============================================================================
module weight_packer_16
    import weight_packer_16_pkg::*;
#(
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int LANES        = PACK_LANES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WEIGHT_WIDTH-1:0]       in_data_i,
    input  logic                          in_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [LANES*WEIGHT_WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0]              out_count_o
);

    pack_state_e      state_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_valid_q;

    logic in_fire;
    logic out_fire;
    logic grp_close;
    logic clr_lanes;

    // While a group is held, a new operand can only enter as the old group leaves.
    assign in_ready_o = rst_n & ((state_q == ST_FILL) | out_ready_i);
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = out_valid_q & out_ready_i;
    assign grp_close  = in_last_i | (idx_q == CNT_W'(LANES - 1));
    assign clr_lanes  = (state_q == ST_FULL) & out_fire;

    assign out_valid_o = out_valid_q;
    assign out_count_o = out_count_q;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic                    wr_en;
            logic [WEIGHT_WIDTH-1:0] lane_d;
            logic [WEIGHT_WIDTH-1:0] lane_q;

            // In FULL the only writable lane is 0: the first operand of the next group.
            assign wr_en = in_fire & ((state_q == ST_FILL) ? (idx_q == CNT_W'(k)) : (k == 0));

            always_comb begin
                lane_d = lane_q;
                if (clr_lanes) begin
                    lane_d = '0;
                end
                if (wr_en) begin
                    lane_d = in_data_i;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= '0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign out_data_o[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = lane_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_fire) begin
                        if (grp_close) begin
                            state_q     <= ST_FULL;
                            out_valid_q <= 1'b1;
                            out_count_q <= idx_q + CNT_W'(1);
                            idx_q       <= '0;
                        end else begin
                            idx_q <= idx_q + CNT_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        if (in_fire && in_last_i) begin
                            out_count_q <= CNT_W'(1);
                            idx_q       <= '0;
                        end else begin
                            state_q     <= ST_FILL;
                            out_valid_q <= 1'b0;
                            out_count_q <= '0;
                            idx_q       <= in_fire ? CNT_W'(1) : '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

endmodule : weight_packer_16
`default_nettype wire

// File: tb/tb_weight_packer_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_packer_16
// Brief    : Self-checking bench for weight_packer_16 against a group-level model.
// Revision : 1.0
// ============================================================================
module tb_weight_packer_16;

    localparam int W = 8;
    localparam int L = 16;
    localparam int C = 5;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] out_data;
    logic [C-1:0]   out_count;

    weight_packer_16 #(.WEIGHT_WIDTH(W), .LANES(L), .CNT_W(C)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_count_o(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] data;
        int             count;
    } grp_t;

    typedef struct {
        int       n;
        logic [W-1:0] ops [L];
        bit       last;
        int       exp_count;
        int       exp_sum;
        logic [W-1:0] exp_l0;
        logic [W-1:0] exp_l15;
    } vec_t;

    logic [W-1:0]   cur [$];
    grp_t           exp_q [$];
    int             checks = 0;
    int             errors = 0;
    bit             got_out;
    logic [L*W-1:0] got_data;
    logic [C-1:0]   got_count;
    int             n_out;
    bit             last_accepted;
    vec_t           tbl [5];

    task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; outputs checked on the falling edge, model advanced after the rising edge.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit l, input bit ordy);
        bit exp_rdy;
        bit ofire;
        bit ifire;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (exp_q.size() == 0) || ordy;
        chk("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
        chk("out_valid", {127'b0, out_valid}, {127'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_count", {123'b0, out_count}, (L*W)'(exp_q[0].count));
        end
        ofire = (exp_q.size() != 0) && ordy;
        ifire = v && exp_rdy;
        if (ofire) begin
            got_out   = 1'b1;
            got_data  = out_data;
            got_count = out_count;
            n_out++;
        end
        last_accepted = ifire;
        @(posedge clk);
        #1;
        if (ofire) void'(exp_q.pop_front());
        if (ifire) begin
            cur.push_back(d);
            if (l || cur.size() == L) begin
                grp_t g;
                g.data = '0;
                foreach (cur[i]) g.data[i*W +: W] = cur[i];
                g.count = cur.size();
                exp_q.push_back(g);
                cur.delete();
            end
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit l, input bit ordy);
        int tries;
        tries = 0;
        last_accepted = 1'b0;
        while (!last_accepted && tries < 50) begin
            cycle(1'b1, d, l, ordy);
            tries++;
        end
        if (!last_accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", {127'b0, out_valid}, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_count", {123'b0, out_count}, '0);
        chk("rst_in_ready", {127'b0, in_ready}, '0);
        cur.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        for (int i = 0; i < L; i++) begin
            tbl[0].ops[i] = W'(i + 1);
            tbl[1].ops[i] = (i == 0 || i == L - 1) ? 8'd3 : 8'd0;
            tbl[2].ops[i] = (i == 0) ? 8'd4 : 8'd0;
            tbl[3].ops[i] = (i < 3) ? W'(i + 5) : 8'd0;
            tbl[4].ops[i] = 8'hFF;
        end
        tbl[0].n = 16; tbl[0].last = 0; tbl[0].exp_count = 16; tbl[0].exp_sum = 136;  tbl[0].exp_l0 = 1;   tbl[0].exp_l15 = 16;
        tbl[1].n = 16; tbl[1].last = 0; tbl[1].exp_count = 16; tbl[1].exp_sum = 6;    tbl[1].exp_l0 = 3;   tbl[1].exp_l15 = 3;
        tbl[2].n = 1;  tbl[2].last = 1; tbl[2].exp_count = 1;  tbl[2].exp_sum = 4;    tbl[2].exp_l0 = 4;   tbl[2].exp_l15 = 0;
        tbl[3].n = 3;  tbl[3].last = 1; tbl[3].exp_count = 3;  tbl[3].exp_sum = 18;   tbl[3].exp_l0 = 5;   tbl[3].exp_l15 = 0;
        tbl[4].n = 16; tbl[4].last = 1; tbl[4].exp_count = 16; tbl[4].exp_sum = 4080; tbl[4].exp_l0 = 255; tbl[4].exp_l15 = 255;

        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0; out_ready = 1'b1;
        #3;
        chk("init_out_valid", {127'b0, out_valid}, '0);
        chk("init_out_data", out_data, '0);
        chk("init_out_count", {123'b0, out_count}, '0);
        chk("init_in_ready", {127'b0, in_ready}, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[t]) begin
            got_out = 1'b0;
            for (int i = 0; i < tbl[t].n; i++)
                cycle(1'b1, tbl[t].ops[i], tbl[t].last && (i == tbl[t].n - 1), 1'b1);
            for (int j = 0; j < 4 && !got_out; j++)
                cycle(1'b0, 8'h00, 1'b0, 1'b1);
            chk("tbl_group_seen", {127'b0, got_out}, 1);
            if (got_out) begin
                sum = 0;
                for (int k = 0; k < L; k++) sum += int'(got_data[k*W +: W]);
                chk("tbl_count", {123'b0, got_count}, (L*W)'(tbl[t].exp_count));
                chk("tbl_sum", (L*W)'(sum), (L*W)'(tbl[t].exp_sum));
                chk("tbl_lane0", {120'b0, got_data[7:0]}, {120'b0, tbl[t].exp_l0});
                chk("tbl_lane15", {120'b0, got_data[L*W-1 -: W]}, {120'b0, tbl[t].exp_l15});
            end
        end

        // Backpressure: full group held 10 clocks while an operand waits.
        for (int i = 0; i < L; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b1);
        for (int i = 1; i < L; i++) send(W'(i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Held group leaves while a single-operand last group enters.
        for (int i = 0; i < L; i++) send(W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h4C, 1'b1, 1'b0);
        send(8'h4C, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // 48 back-to-back operands: every one accepted, three groups.
        n_out = 0;
        for (int i = 0; i < 48; i++) begin
            cycle(1'b1, W'(i * 7 + 1), 1'b0, 1'b1);
            chk("stream_accept", {127'b0, last_accepted}, 1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("stream_groups", (L*W)'(n_out), 3);

        // Reset mid-group, then reset with a group held.
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(i + 100), 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < L; i++) cycle(1'b1, W'(i + 40), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < L; i++) cycle(1'b1, W'(i + 200), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < L; i++) cycle(1'b1, W'(i + 9), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_weight_packer_16
`default_nettype wire
